// File: rtl/seq_detector_ctrl_pkg.sv
// Shared types and default widths for the serial pattern detector controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

  localparam int WORD_W_DEF = 8;
  localparam int PAT_W_DEF  = 4;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/seq_detector_ctrl_word_serializer.sv
// Parallel-to-serial shifter with bit index; MSB-first by default,
// LSB-first when SEQ_DETECTOR_CTRL_LSB_FIRST_EN is defined.
module word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              bit_out,
  output logic              last_bit
);

  localparam int IDX_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;
  logic              first_bit;
  logic              next_bit;
  logic [WORD_W-1:0] data_adv;
  logic [WORD_W-1:0] sreg_adv;

`ifdef SEQ_DETECTOR_CTRL_LSB_FIRST_EN
  assign first_bit = data[0];
  assign next_bit  = sreg[0];
  assign data_adv  = data >> 1;
  assign sreg_adv  = sreg >> 1;
`else
  assign first_bit = data[WORD_W-1];
  assign next_bit  = sreg[WORD_W-1];
  assign data_adv  = data << 1;
  assign sreg_adv  = sreg << 1;
`endif

  // idx counts bits already presented on bit_out for the current word
  always_ff @(posedge clock) begin
    if (!reset) begin
      sreg    <= '0;
      idx     <= '0;
      bit_out <= 1'b0;
    end else if (load) begin
      bit_out <= first_bit;
      sreg    <= data_adv;
      idx     <= IDX_W'(1);
    end else if (shift) begin
      bit_out <= next_bit;
      sreg    <= sreg_adv;
      idx     <= idx + IDX_W'(1);
    end
  end

  assign last_bit = (idx == IDX_W'(WORD_W));

endmodule

// File: rtl/seq_detector_ctrl.sv
// Sequences a serial pattern detector: pattern load, detector clear, word
// serialization and saturating match counting. Bit order set by SEQ_DETECTOR_CTRL_LSB_FIRST_EN.
module seq_detector_ctrl #(
  parameter int WORD_W = seq_det_pkg::WORD_W_DEF,
  parameter int PAT_W  = seq_det_pkg::PAT_W_DEF,
  parameter int CNT_W  = seq_det_pkg::CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [PAT_W-1:0]  cfg_pattern,
  output logic              cfg_ready,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              det_reset,
  output logic [PAT_W-1:0]  det_pattern,
  output logic              det_sequence,
  input  logic              det_flag,
  output logic [CNT_W-1:0]  match_count,
  output logic              match_pulse,
  output logic              overflow,
  output logic              busy
);

  import seq_det_pkg::*;

  ctrl_state_t      state;
  logic             last_bit;
  logic             cfg_take;
  logic             word_take;
  logic             shift_en;
  logic             counting;
  logic [CNT_W:0]   inc_res;

  // Returns {saturated, next_count}; the count holds at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == '1) return {1'b1, c};
    return {1'b0, c + CNT_W'(1)};
  endfunction

  assign cfg_ready  = (state == IDLE);
  assign word_ready = ((state == IDLE) && !cfg_valid) ||
                      ((state == SHIFT) && last_bit);
  assign cfg_take   = cfg_ready && cfg_valid;
  assign word_take  = word_ready && word_valid;
  assign shift_en   = (state == SHIFT) && !last_bit;
  assign counting   = (state == SHIFT) || (state == DRAIN);
  assign busy       = (state != IDLE);
  assign det_reset  = !reset || (state == CLEAR);
  assign inc_res    = sat_inc(match_count);

  word_serializer #(
    .WORD_W(WORD_W)
  ) u_ser (
    .clock   (clock),
    .reset   (reset),
    .load    (word_take),
    .shift   (shift_en),
    .data    (word_data),
    .bit_out (det_sequence),
    .last_bit(last_bit)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      det_pattern <= '0;
      match_count <= '0;
      match_pulse <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      // flag lags the presented bit by one cycle, hence DRAIN is counted too
      if (counting && det_flag) begin
        match_pulse <= 1'b1;
        match_count <= inc_res[CNT_W-1:0];
        if (inc_res[CNT_W]) overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_take) begin
            det_pattern <= cfg_pattern;
            match_count <= '0;
            overflow    <= 1'b0;
            state       <= CLEAR;
          end else if (word_take) begin
            state <= SHIFT;
          end
        end
        CLEAR: state <= IDLE;
        SHIFT: begin
          if (last_bit && !word_valid) state <= DRAIN;
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detector_ctrl.sv
// Directed bench for seq_detector_ctrl with a 4-bit window-compare detector model.
module tb_seq_detector_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic [3:0] cfg_pattern;
  logic       cfg_ready, cfg_ready2;
  logic       word_valid;
  logic [7:0] word_data;
  logic       word_ready, word_ready2;
  logic       det_reset, det_reset2;
  logic [3:0] det_pattern, det_pattern2;
  logic       det_sequence, det_sequence2;
  logic       det_flag;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic       match_pulse, match_pulse2;
  logic       overflow, overflow2;
  logic       busy, busy2;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pulses2 = 0;

  logic exp26[8];
  logic exp22[8];

  always #5 clock = ~clock;

  seq_detector_ctrl dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_ready(cfg_ready),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .det_reset(det_reset), .det_pattern(det_pattern), .det_sequence(det_sequence),
    .det_flag(det_flag), .match_count(match_count), .match_pulse(match_pulse),
    .overflow(overflow), .busy(busy)
  );

  seq_detector_ctrl #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_ready(cfg_ready2),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready2),
    .det_reset(det_reset2), .det_pattern(det_pattern2), .det_sequence(det_sequence2),
    .det_flag(det_flag), .match_count(match_count2), .match_pulse(match_pulse2),
    .overflow(overflow2), .busy(busy2)
  );

  // Detector model: registered flag from a 4-bit window, cleared by det_reset.
  logic [3:0] win;
  always @(posedge clock) begin
    if (det_reset) begin
      win      <= 4'd0;
      det_flag <= 1'b0;
    end else begin
      win      <= {win[2:0], det_sequence};
      det_flag <= ({win[2:0], det_sequence} == det_pattern);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (match_pulse) pulses++;
    if (match_pulse2) pulses2++;
  endtask

  initial begin
`ifdef SEQ_DETECTOR_CTRL_LSB_FIRST_EN
    exp26 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp22 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp26 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp22 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    // reset held with both offers active
    reset = 1'b0; cfg_valid = 1'b1; word_valid = 1'b1;
    cfg_pattern = 4'b0010; word_data = 8'h26;
    tick(); tick(); tick();
    check("rst_det_reset", 32'(det_reset), 32'd1);
    check("rst_pattern", 32'(det_pattern), 32'd0);
    check("rst_sequence", 32'(det_sequence), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_pulse", 32'(match_pulse), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    reset = 1'b1; cfg_valid = 1'b0; word_valid = 1'b0;
    tick();
    check("idle_det_reset", 32'(det_reset), 32'd0);

    // simultaneous cfg and word offer: cfg wins
    cfg_valid = 1'b1; word_valid = 1'b1; word_data = 8'h26;
    #1;
    check("sim_cfg_ready", 32'(cfg_ready), 32'd1);
    check("sim_word_ready", 32'(word_ready), 32'd0);
    tick();
    check("clr_det_reset", 32'(det_reset), 32'd1);
    check("clr_pattern", 32'(det_pattern), 32'd2);
    check("clr_cfg_ready", 32'(cfg_ready), 32'd0);
    check("clr_word_ready", 32'(word_ready), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    cfg_valid = 1'b0;
    tick();
    check("post_clr_det_reset", 32'(det_reset), 32'd0);
    check("post_clr_word_ready", 32'(word_ready), 32'd1);
    tick();
    word_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("w26_bit%0d", i), 32'(det_sequence), 32'(exp26[i]));
      if (i == 0) check("w26_ready_first", 32'(word_ready), 32'd0);
      if (i == 7) check("w26_ready_last", 32'(word_ready), 32'd1);
      tick();
    end
    check("w26_drain_busy", 32'(busy), 32'd1);
    check("w26_drain_hold", 32'(det_sequence), 32'(exp26[7]));
    tick();
    check("w26_idle_busy", 32'(busy), 32'd0);
    check("w26_count", 32'(match_count), 32'd1);
    check("w26_pulses", 32'(pulses), 32'd1);

    // back-to-back 8'h22 words after a fresh cfg
    cfg_valid = 1'b1; cfg_pattern = 4'b0010;
    tick();
    check("b2b_cfg_count_clear", 32'(match_count), 32'd0);
    cfg_valid = 1'b0; word_valid = 1'b1; word_data = 8'h22;
    tick();
    tick();
    pulses = 0; pulses2 = 0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_bit%0d", i), 32'(det_sequence), 32'(exp22[i % 8]));
      if (i == 7) check("b2b_ready_last", 32'(word_ready), 32'd1);
      if (i == 8) begin
        check("b2b_second_busy", 32'(busy), 32'd1);
        word_valid = 1'b0;
      end
      tick();
    end
    check("b2b_drain_busy", 32'(busy), 32'd1);
    tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_count", 32'(match_count), 32'd4);
    check("b2b_pulses", 32'(pulses), 32'd4);
    check("b2b_overflow", 32'(overflow), 32'd0);
    check("sat_count", 32'(match_count2), 32'd3);
    check("sat_overflow", 32'(overflow2), 32'd1);
    check("sat_pulses", 32'(pulses2), 32'd4);

    // new cfg clears saturated count and overflow
    cfg_valid = 1'b1;
    tick();
    check("sat_clr_count", 32'(match_count2), 32'd0);
    check("sat_clr_overflow", 32'(overflow2), 32'd0);
    check("clr_count_main", 32'(match_count), 32'd0);
    cfg_valid = 1'b0;
    tick();

    // reset during bit 4 of a word
    word_valid = 1'b1; word_data = 8'h26;
    tick();
    word_valid = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("mid_det_reset", 32'(det_reset), 32'd1);
    tick();
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_count", 32'(match_count), 32'd0);
    check("mid_sequence", 32'(det_sequence), 32'd0);
    check("mid_pulse", 32'(match_pulse), 32'd0);
    reset = 1'b1;
    cfg_valid = 1'b1; cfg_pattern = 4'b0010;
    tick();
    cfg_valid = 1'b0;
    tick();
    word_valid = 1'b1; word_data = 8'h26;
    tick();
    word_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rw_bit%0d", i), 32'(det_sequence), 32'(exp26[i]));
      tick();
    end
    tick();
    check("rw_idle_busy", 32'(busy), 32'd0);
    check("rw_count", 32'(match_count), 32'd1);
    check("rw_pulses", 32'(pulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the summary within 20000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detector_ctrl.md
Name: seq_detector_ctrl

Overview:
Controller that sequences the serial pattern detector. It takes pattern configuration and parallel data words over valid/ready handshakes, then clears the detector and drives its pattern and serial bit inputs. It shifts each word out one bit per clock, samples the detector flag and keeps a match count. It sits between the parallel data source and one detector instance.

Parameters:
WORD_W, 8, bits per data word serialized into the detector
PAT_W, 4, detector pattern width
CNT_W, 8, match counter width

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
cfg_valid  in  1  new pattern offered
cfg_pattern  in  PAT_W  pattern to detect
cfg_ready  out  1  controller can accept a pattern
word_valid  in  1  data word offered
word_data  in  WORD_W  data word
word_ready  out  1  controller can accept a word
det_reset  out  1  active-high clear to the detector
det_pattern  out  PAT_W  pattern driven to the detector
det_sequence  out  1  serial bit to the detector
det_flag  in  1  detector match flag
match_count  out  CNT_W  matches since last pattern load
match_pulse  out  1  one-cycle strobe per counted match
overflow  out  1  sticky, set when the counter saturates
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; det_pattern=0, det_sequence=0, match_count=0, match_pulse=0, overflow=0, bit index=0.
  - det_reset=1 combinationally while reset==0.
- States and transitions:
  - IDLE: cfg_ready=1.
    - word_ready=1 only if cfg_valid==0, so config wins a simultaneous offer.
    - cfg handshake: latch det_pattern, clear match_count and overflow, go to CLEAR.
    - word handshake: load shift register, det_sequence<=first bit, index=1, go to SHIFT.
  - CLEAR: det_reset=1 for exactly one cycle, cfg_ready=word_ready=0, then IDLE.
  - SHIFT: det_sequence<=next bit each edge. After WORD_W bits have been presented:
    - if word_valid, accept the next word back-to-back (word_ready=1 only in this last-bit cycle), with no gap bit and no DRAIN;
    - otherwise go to DRAIN.
  - DRAIN: one cycle, lets the detector flag for the final bit be sampled, then IDLE.
- Bit order: MSB-first (word_data[WORD_W-1] first). A word occupies exactly WORD_W consecutive det_sequence cycles.
- det_sequence holds its last value in IDLE/CLEAR/DRAIN. det_reset=0 outside CLEAR and reset.
- Counting:
  - In SHIFT and DRAIN, each cycle with det_flag==1 increments match_count and asserts match_pulse the next cycle.
  - det_flag is ignored in IDLE and CLEAR.
- Saturation: at match_count == 2^CNT_W-1, a further flag holds the count, sets overflow (sticky until the next cfg load or reset) and still pulses match_pulse.
- Detector history persists across words. Only a cfg load or reset clears the detector.
- Reset mid-word aborts the word silently: no partial count is retained and the detector is cleared via det_reset.
- cfg_valid during SHIFT/DRAIN/CLEAR is stalled (cfg_ready=0), never dropped.

Optional Feature:
- Macro SEQ_DETECTOR_CTRL_LSB_FIRST_EN.
- Defined: words are serialized LSB-first (word_data[0] first).
- Undefined: MSB-first as above.
- Timing and handshake are identical in both cases.

Decomposition:
- Shared package seq_det_pkg holds:
  - state enum ctrl_state_t {IDLE, CLEAR, SHIFT, DRAIN};
  - default widths WORD_W_DEF=8, PAT_W_DEF=4, CNT_W_DEF=8.
- One sub-module, word_serializer: load/shift register plus bit index, with a last_bit output. The FSM and counter stay in the top level.

Test Plan:
- Reset held low 3 cycles with cfg_valid/word_valid=1 -> all outputs at reset values, det_reset=1, no handshake completes.
- cfg 4'b0010 then word 8'h26, bench detector = 4-bit window compare -> det_sequence 0,0,1,0,0,1,1,0 on consecutive cycles; det_reset high exactly one cycle; match_count=1; single match_pulse.
- cfg_valid and word_valid together in IDLE -> cfg accepted, word_ready=0 that cycle, word accepted after CLEAR.
- Words 8'h22 then 8'h22 held valid -> second accepted in the last-bit cycle, 16 contiguous bits, no DRAIN between words, match_count=4 (pattern 0010: two matches per word).
- CNT_W=2, stream of 8'h22 words -> count stops at 3, overflow=1, match_pulse continues; new cfg clears count and overflow to 0.
- reset low during bit 4 of a word -> next cycle state=IDLE, match_count=0; a subsequent word is serialized from bit 0. With SEQ_DETECTOR_CTRL_LSB_FIRST_EN, word 8'h26 emits 0,1,1,0,0,1,0,0.
